// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/control unit for an in-order pipeline of STAGES stages.
// Tracks the instructions from EX onward and derives stall, flush, bubble and
// EX operand-forwarding selects, plus saturating load-use/branch-flush counters.
`timescale 1ns/1ps
module pipeline_hazard_ctrl #(
  parameter int STAGES = 5,
  parameter int AW     = 5,
  parameter int CNT_W  = 32,
  parameter int FW     = $clog2(STAGES-2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [AW-1:0]     id_rs1,
  input  logic [AW-1:0]     id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [AW-1:0]     id_rd,
  input  logic              id_regwrite,
  input  logic              id_load,
  input  logic              ex_branch_taken,
  input  logic              stall_ext,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_id,
  output logic              bubble_ex,
  output logic [FW-1:0]     fwd_a_sel,
  output logic [FW-1:0]     fwd_b_sel,
  output logic [STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned WB      = STAGES - 1;
  localparam int unsigned LU_LAST = STAGES - 3;

  logic              run;
  logic [STAGES-1:2] t_v, t_rw, t_ld;
  logic [AW-1:0]     t_rd [2:STAGES-1];
  logic [AW-1:0]     ex_rs1, ex_rs2;
  logic              ex_use1, ex_use2;
  logic              lu, br_evt, lu_evt;

  // Load-use: a load still too young to forward feeds a source used in ID.
  always_comb begin
    lu = 1'b0;
    for (int unsigned s = 2; s <= LU_LAST; s++) begin
      if (t_v[s] && t_ld[s] && t_rd[s] != '0 &&
          ((id_use_rs1 && t_rd[s] == id_rs1) || (id_use_rs2 && t_rd[s] == id_rs2)))
        lu = 1'b1;
    end
    lu = lu & id_valid;
  end

  // Forward select: scan oldest to youngest so the youngest match is kept.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    for (int unsigned s = WB; s >= 3; s--) begin
      if (t_v[s] && t_rw[s] && t_rd[s] != '0 && (!t_ld[s] || s == WB)) begin
        if (t_v[2] && ex_use1 && t_rd[s] == ex_rs1) fwd_a_sel = FW'(s - 2);
        if (t_v[2] && ex_use2 && t_rd[s] == ex_rs2) fwd_b_sel = FW'(s - 2);
      end
    end
  end

  // Control outputs by priority: external freeze, taken branch, load-use.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    br_evt    = !stall_ext && ex_branch_taken;
    lu_evt    = !stall_ext && !ex_branch_taken && lu;
    if (!rst) begin
      if (stall_ext) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
      end else if (ex_branch_taken) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (lu) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  assign stage_valid = {t_v, id_valid & ~rst, run};

  // Tracking registers advance unless frozen; counters saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run       <= 1'b0;
      t_v       <= '0;
      t_rw      <= '0;
      t_ld      <= '0;
      for (int unsigned s = 2; s <= WB; s++) t_rd[s] <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_use1   <= 1'b0;
      ex_use2   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (!stall_ext) begin
        for (int unsigned s = 3; s <= WB; s++) begin
          t_v[s]  <= t_v[s-1];
          t_rw[s] <= t_rw[s-1];
          t_ld[s] <= t_ld[s-1];
          t_rd[s] <= t_rd[s-1];
        end
        if (bubble_ex) begin
          t_v[2]  <= 1'b0;
          t_rw[2] <= 1'b0;
          t_ld[2] <= 1'b0;
          t_rd[2] <= '0;
          ex_rs1  <= '0;
          ex_rs2  <= '0;
          ex_use1 <= 1'b0;
          ex_use2 <= 1'b0;
        end else begin
          t_v[2]  <= id_valid;
          t_rw[2] <= id_regwrite;
          t_ld[2] <= id_load;
          t_rd[2] <= id_rd;
          ex_rs1  <= id_rs1;
          ex_rs2  <= id_rs2;
          ex_use1 <= id_use_rs1;
          ex_use2 <= id_use_rs2;
        end
      end
      if (lu_evt && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (br_evt && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a 5-stage and a 6-stage instance share inputs.
// Each is checked every cycle against a queue-based pipeline model, plus a
// directed table and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_branch_taken, stall_ext;

  logic        s5_sif, s5_sid, s5_fid, s5_bex;
  logic [1:0]  s5_fa, s5_fb;
  logic [4:0]  s5_sv;
  logic [31:0] s5_sc, s5_fc;
  logic        s6_sif, s6_sid, s6_fid, s6_bex;
  logic [1:0]  s6_fa, s6_fb;
  logic [5:0]  s6_sv;
  logic [2:0]  s6_sc, s6_fc;

  pipeline_hazard_ctrl #(.STAGES(5)) dut5 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_load(id_load), .ex_branch_taken(ex_branch_taken),
    .stall_ext(stall_ext), .stall_if(s5_sif), .stall_id(s5_sid), .flush_id(s5_fid),
    .bubble_ex(s5_bex), .fwd_a_sel(s5_fa), .fwd_b_sel(s5_fb), .stage_valid(s5_sv),
    .stall_cnt(s5_sc), .flush_cnt(s5_fc));

  pipeline_hazard_ctrl #(.STAGES(6), .CNT_W(3)) dut6 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_load(id_load), .ex_branch_taken(ex_branch_taken),
    .stall_ext(stall_ext), .stall_if(s6_sif), .stall_id(s6_sid), .flush_id(s6_fid),
    .bubble_ex(s6_bex), .fwd_a_sel(s6_fa), .fwd_b_sel(s6_fb), .stage_valid(s6_sv),
    .stall_cnt(s6_sc), .flush_cnt(s6_fc));

  typedef struct packed {
    logic sx, br, iv; logic [4:0] rs1, rs2; logic u1, u2; logic [4:0] rd; logic rw, ld;
  } ins_t;
  typedef struct packed {
    logic v; logic [4:0] rd; logic rw, ld; logic [4:0] rs1, rs2; logic u1, u2;
  } rec_t;
  typedef struct packed {
    logic sif, sid, fid, bex; logic [1:0] fa, fb; logic [7:0] sv;
  } exp_t;
  typedef struct packed {
    ins_t in; logic [3:0] ctl; logic [1:0] fa, fb;
  } row_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  rec_t   q[2][$];
  longint sc[2], fc[2];
  bit     mrun[2];
  ins_t   cur;
  row_t   tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic ins_t mk(input int sx, input int br, input int iv, input int rs1,
                              input int rs2, input int u1, input int u2, input int rd,
                              input int rw, input int ld);
    ins_t r;
    r.sx = 1'(sx); r.br = 1'(br); r.iv = 1'(iv); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
    r.u1 = 1'(u1); r.u2 = 1'(u2); r.rd = 5'(rd); r.rw = 1'(rw); r.ld = 1'(ld);
    return r;
  endfunction

  function automatic ins_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Model: pq[0] is EX, pq[n-3] is WB.
  function automatic bit lu_of(input rec_t pq[$], input int n, input ins_t in);
    bit l = 1'b0;
    for (int i = 0; i <= n - 5; i++)
      if (pq[i].v && pq[i].ld && pq[i].rd != 0 &&
          ((in.u1 && pq[i].rd == in.rs1) || (in.u2 && pq[i].rd == in.rs2)))
        l = 1'b1;
    return l && in.iv;
  endfunction

  function automatic logic [1:0] fwd_of(input rec_t pq[$], input int n,
                                        input logic [4:0] rs, input logic use_bit);
    if (!pq[0].v || !use_bit || rs == 0) return 2'd0;
    for (int i = 1; i <= n - 3; i++)
      if (pq[i].v && pq[i].rw && pq[i].rd == rs && (!pq[i].ld || i == n - 3)) return 2'(i);
    return 2'd0;
  endfunction

  function automatic exp_t predict(input rec_t pq[$], input int n, input ins_t in, input bit rn);
    exp_t e = '0;
    bit   l = lu_of(pq, n, in);
    if (in.sx) begin e.sif = 1; e.sid = 1; end
    else if (in.br) begin e.fid = 1; e.bex = 1; end
    else if (l) begin e.sif = 1; e.sid = 1; e.bex = 1; end
    e.fa = fwd_of(pq, n, pq[0].rs1, pq[0].u1);
    e.fb = fwd_of(pq, n, pq[0].rs2, pq[0].u2);
    e.sv[0] = rn;
    e.sv[1] = in.iv;
    for (int i = 0; i <= n - 3; i++) e.sv[2+i] = pq[i].v;
    return e;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      q[m].delete();
      repeat (3 + m) q[m].push_back('0);
      sc[m] = 0; fc[m] = 0; mrun[m] = 1'b0;
    end
  endtask

  task automatic model_adv(input int m);
    longint cmax = (m == 0) ? 64'hFFFF_FFFF : 7;
    bit     l    = lu_of(q[m], 5 + m, cur);
    rec_t   r    = '0;
    mrun[m] = 1'b1;
    if (!cur.sx) begin
      if (cur.br) begin if (fc[m] < cmax) fc[m]++; end
      else if (l) begin if (sc[m] < cmax) sc[m]++; end
      if (!cur.br && !l) begin
        r.v = cur.iv; r.rd = cur.rd; r.rw = cur.rw; r.ld = cur.ld;
        r.rs1 = cur.rs1; r.rs2 = cur.rs2; r.u1 = cur.u1; r.u2 = cur.u2;
      end
      q[m].push_front(r);
      void'(q[m].pop_back());
    end
  endtask

  task automatic check_model(input int m);
    exp_t e = predict(q[m], 5 + m, cur, mrun[m]);
    if (m == 0) begin
      chk("m5 stall_if", 64'(s5_sif), 64'(e.sif));
      chk("m5 stall_id", 64'(s5_sid), 64'(e.sid));
      chk("m5 flush_id", 64'(s5_fid), 64'(e.fid));
      chk("m5 bubble_ex", 64'(s5_bex), 64'(e.bex));
      chk("m5 fwd_a", 64'(s5_fa), 64'(e.fa));
      chk("m5 fwd_b", 64'(s5_fb), 64'(e.fb));
      chk("m5 stage_valid", 64'(s5_sv), 64'(e.sv[4:0]));
      chk("m5 stall_cnt", 64'(s5_sc), 64'(sc[0]));
      chk("m5 flush_cnt", 64'(s5_fc), 64'(fc[0]));
    end else begin
      chk("m6 stall_if", 64'(s6_sif), 64'(e.sif));
      chk("m6 stall_id", 64'(s6_sid), 64'(e.sid));
      chk("m6 flush_id", 64'(s6_fid), 64'(e.fid));
      chk("m6 bubble_ex", 64'(s6_bex), 64'(e.bex));
      chk("m6 fwd_a", 64'(s6_fa), 64'(e.fa));
      chk("m6 fwd_b", 64'(s6_fb), 64'(e.fb));
      chk("m6 stage_valid", 64'(s6_sv), 64'(e.sv[5:0]));
      chk("m6 stall_cnt", 64'(s6_sc), 64'(sc[1]));
      chk("m6 flush_cnt", 64'(s6_fc), 64'(fc[1]));
    end
  endtask

  task automatic drive(input ins_t in);
    stall_ext = in.sx; ex_branch_taken = in.br; id_valid = in.iv;
    id_rs1 = in.rs1; id_rs2 = in.rs2; id_use_rs1 = in.u1; id_use_rs2 = in.u2;
    id_rd = in.rd; id_regwrite = in.rw; id_load = in.ld;
  endtask

  // Called at posedge+1; returns at the following negedge after model checks.
  task automatic step_begin(input ins_t in);
    cur = in;
    drive(in);
    @(negedge clk);
    check_model(0);
    check_model(1);
  endtask

  task automatic step_end();
    model_adv(0);
    model_adv(1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step(input ins_t in);
    step_begin(in);
    step_end();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " s5 ctl"}, 64'({s5_sif, s5_sid, s5_fid, s5_bex}), 0);
    chk({tag, " s5 fwd"}, 64'({s5_fa, s5_fb}), 0);
    chk({tag, " s5 stage_valid"}, 64'(s5_sv), 0);
    chk({tag, " s5 counters"}, 64'({s5_sc, s5_fc}), 0);
    chk({tag, " s6 ctl"}, 64'({s6_sif, s6_sid, s6_fid, s6_bex}), 0);
    chk({tag, " s6 fwd"}, 64'({s6_fa, s6_fb}), 0);
    chk({tag, " s6 stage_valid"}, 64'(s6_sv), 0);
    chk({tag, " s6 counters"}, 64'({s6_sc, s6_fc}), 0);
  endtask

  function automatic ins_t rnd();
    ins_t r;
    r.sx  = ($urandom_range(0, 9) == 0);
    r.br  = ($urandom_range(0, 9) == 0);
    r.iv  = ($urandom_range(0, 3) != 0);
    r.rs1 = 5'($urandom_range(0, 3));
    r.rs2 = 5'($urandom_range(0, 3));
    r.u1  = ($urandom_range(0, 3) != 0);
    r.u2  = ($urandom_range(0, 1) != 0);
    r.rd  = 5'($urandom_range(0, 3));
    r.rw  = ($urandom_range(0, 3) != 0);
    r.ld  = ($urandom_range(0, 2) == 0);
    return r;
  endfunction

  initial begin
    //                 sx br iv rs1 rs2 u1 u2 rd rw ld      sif/sid/fid/bex fa fb   (5-stage)
    tbl[0]  = {mk(0, 0, 1, 1, 0, 1, 0, 5, 1, 1), 4'b0000, 2'd0, 2'd0}; // lw x5
    tbl[1]  = {mk(0, 0, 1, 5, 1, 1, 1, 6, 1, 0), 4'b1101, 2'd0, 2'd0}; // add x6,x5,x1 -> stall
    tbl[2]  = {mk(0, 0, 1, 5, 1, 1, 1, 6, 1, 0), 4'b0000, 2'd0, 2'd0}; // add held, lw in MEM
    tbl[3]  = {nop(),                            4'b0000, 2'd2, 2'd0}; // add in EX, lw in WB
    tbl[4]  = {mk(0, 0, 1, 1, 2, 1, 1, 3, 1, 0), 4'b0000, 2'd0, 2'd0}; // add x3 (A)
    tbl[5]  = {mk(0, 0, 1, 1, 2, 1, 1, 3, 1, 0), 4'b0000, 2'd0, 2'd0}; // add x3 (B)
    tbl[6]  = {mk(0, 0, 1, 3, 3, 1, 1, 4, 1, 0), 4'b0000, 2'd0, 2'd0}; // sub x4,x3,x3
    tbl[7]  = {nop(),                            4'b0000, 2'd1, 2'd1}; // sub EX, B MEM, A WB
    tbl[8]  = {mk(0, 0, 1, 1, 2, 1, 1, 0, 1, 0), 4'b0000, 2'd0, 2'd0}; // add x0
    tbl[9]  = {mk(0, 0, 1, 0, 0, 1, 1, 7, 1, 0), 4'b0000, 2'd0, 2'd0}; // or x7,x0,x0
    tbl[10] = {nop(),                            4'b0000, 2'd0, 2'd0}; // x0 writer in MEM
    tbl[11] = {mk(0, 0, 1, 1, 0, 1, 0, 0, 1, 1), 4'b0000, 2'd0, 2'd0}; // lw x0
    tbl[12] = {mk(0, 0, 1, 0, 0, 1, 0, 10, 1, 0), 4'b0000, 2'd0, 2'd0}; // reads x0: no stall
    tbl[13] = {mk(0, 0, 1, 1, 0, 1, 0, 8, 1, 1), 4'b0000, 2'd0, 2'd0}; // lw x8
    tbl[14] = {mk(0, 1, 1, 8, 0, 1, 0, 9, 1, 0), 4'b0011, 2'd0, 2'd0}; // dependent + branch
    tbl[15] = {nop(),                            4'b0000, 2'd0, 2'd0};

    // Reset with active-looking inputs: every output must still read 0.
    drive(mk(1, 1, 1, 1, 1, 1, 1, 1, 1, 1));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    step_begin(nop());
    chk("post-reset run bit", 64'(s5_sv[0]), 0);
    step_end();

    for (int i = 0; i < 16; i++) begin
      step_begin(tbl[i].in);
      chk($sformatf("row%0d stall_if", i), 64'(s5_sif), 64'(tbl[i].ctl[3]));
      chk($sformatf("row%0d stall_id", i), 64'(s5_sid), 64'(tbl[i].ctl[2]));
      chk($sformatf("row%0d flush_id", i), 64'(s5_fid), 64'(tbl[i].ctl[1]));
      chk($sformatf("row%0d bubble_ex", i), 64'(s5_bex), 64'(tbl[i].ctl[0]));
      chk($sformatf("row%0d fwd_a", i), 64'(s5_fa), 64'(tbl[i].fa));
      chk($sformatf("row%0d fwd_b", i), 64'(s5_fb), 64'(tbl[i].fb));
      step_end();
    end
    chk("table s5 stall_cnt", 64'(s5_sc), 1);
    chk("table s5 flush_cnt", 64'(s5_fc), 1);
    chk("table s6 stall_cnt", 64'(s6_sc), 2);
    chk("table s6 flush_cnt", 64'(s6_fc), 1);
    repeat (4) step(nop());

    // Six-stage load-use: two stall cycles, then forward from WB (sel 3).
    step(mk(0, 0, 1, 1, 0, 1, 0, 5, 1, 1));
    step_begin(mk(0, 0, 1, 5, 1, 1, 1, 6, 1, 0));
    chk("t2 c1 s6 stall_id", 64'(s6_sid), 1);
    chk("t2 c1 s6 bubble_ex", 64'(s6_bex), 1);
    step_end();
    step_begin(mk(0, 0, 1, 5, 1, 1, 1, 6, 1, 0));
    chk("t2 c2 s6 stall_id", 64'(s6_sid), 1);
    chk("t2 c2 s5 stall_id", 64'(s5_sid), 0);
    step_end();
    step_begin(mk(0, 0, 1, 5, 1, 1, 1, 6, 1, 0));
    chk("t2 c3 s6 stall_id", 64'(s6_sid), 0);
    step_end();
    step_begin(nop());
    chk("t2 s6 fwd_a from WB", 64'(s6_fa), 3);
    step_end();
    chk("t2 s6 stall_cnt", 64'(s6_sc), 4);
    chk("t2 s5 stall_cnt", 64'(s5_sc), 2);
    repeat (4) step(nop());

    // External freeze for 3 cycles (branch during freeze ignored).
    step(mk(0, 0, 1, 1, 0, 1, 0, 11, 1, 0));
    for (int i = 0; i < 3; i++) begin
      step_begin(mk(1, (i == 1) ? 1 : 0, 1, 11, 0, 1, 0, 12, 1, 0));
      chk("t6 freeze stall_if", 64'(s5_sif), 1);
      chk("t6 freeze stall_id", 64'(s5_sid), 1);
      chk("t6 freeze flush_id", 64'(s5_fid), 0);
      chk("t6 freeze bubble_ex", 64'(s5_bex), 0);
      step_end();
    end
    step_begin(mk(0, 0, 1, 11, 0, 1, 0, 12, 1, 0));
    chk("t6 EX held valid", 64'(s5_sv[2]), 1);
    step_end();
    step_begin(nop());
    chk("t6 s5 fwd_a after freeze", 64'(s5_fa), 1);
    chk("t6 s6 fwd_a after freeze", 64'(s6_fa), 1);
    step_end();
    chk("t6 s5 flush_cnt held", 64'(s5_fc), 1);
    chk("t6 s5 stall_cnt held", 64'(s5_sc), 2);

    // Reset pulse while frozen: outputs drop without waiting for a clock.
    step_begin(mk(1, 1, 1, 1, 2, 1, 1, 3, 1, 0));
    chk("pre-rst stall_if", 64'(s5_sif), 1);
    #1 rst = 1'b1;
    #1 check_all_zero("mid-stall reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step_begin(nop());
    chk("after rst s5 run bit", 64'(s5_sv[0]), 0);
    step_end();

    for (int i = 0; i < 1500; i++) step(rnd());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
